// File: rtl/fc_irq_ctrl_gen.sv
// Fabric-controller interrupt controller: pending/mask/mode registers, event FIFO, highest-index-wins request FSM.
// Latency: core_irq_req_o rises one cycle after a masked-in pending bit appears; register reads respond one cycle after the strobe.
// Backpressure: event pushes are dropped while event_fifo_fulln_o is low; the FSM holds a request until ack or withdrawal.
// Optional: define FC_IRQ_ONEHOT_EN to build the one-hot request decode on core_irq_onehot_o.
module fc_irq_ctrl_gen #(
  parameter int NB_IRQ         = 32,
  parameter int EVT_ID_WIDTH   = 8,
  parameter int EVT_FIFO_DEPTH = 8,
  parameter int EVT_IRQ_LINE   = 26,
  parameter int ID_WIDTH       = $clog2(NB_IRQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NB_IRQ-1:0]       irq_lines_i,
  input  logic                    event_fifo_valid_i,
  output logic                    event_fifo_fulln_o,
  input  logic [EVT_ID_WIDTH-1:0] event_fifo_data_i,
  input  logic                    reg_req_i,
  input  logic                    reg_we_i,
  input  logic [2:0]              reg_addr_i,
  input  logic [31:0]             reg_wdata_i,
  output logic [31:0]             reg_rdata_o,
  output logic                    reg_rvalid_o,
  output logic                    core_irq_req_o,
  output logic [ID_WIDTH-1:0]     core_irq_id_o,
  output logic [NB_IRQ-1:0]       core_irq_onehot_o,
  input  logic                    core_irq_ack_i,
  input  logic [ID_WIDTH-1:0]     core_irq_ack_id_i
);

  localparam int AW = $clog2(EVT_FIFO_DEPTH);
  // Lines that physically exist; everything above reads and stores 0.
  localparam logic [31:0] LINE_MASK  = (NB_IRQ >= 32) ? 32'hFFFF_FFFF : ((32'd1 << NB_IRQ) - 32'd1);
  // The event line is owned by the FIFO, so the stored pending bit never holds it.
  localparam logic [31:0] PEND_WMASK = LINE_MASK & ~(32'd1 << EVT_IRQ_LINE);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  logic [31:0] mask_q, mode_q, pend_q, prev_q;
  logic [31:0] lines, pend_eff, pend_d, set_vec, clr_vec, cand;
  logic [31:0] rdata_d;

  logic [EVT_ID_WIDTH-1:0] mem [EVT_FIFO_DEPTH];
  logic [AW:0]             wr_ptr, rd_ptr, count;
  logic                    empty, full, push, pop;

  logic                    rd_acc, wr_acc;
  state_t                  state_q, state_d;
  logic [ID_WIDTH-1:0]     id_q, id_d, sel_id;
  logic                    has_cand, ack_hit;

  assign lines  = 32'(irq_lines_i);
  assign rd_acc = reg_req_i && !reg_we_i;
  assign wr_acc = reg_req_i && reg_we_i;

  // FIFO status comes straight from the registered pointers; the extra pointer bit separates full from empty.
  assign count              = wr_ptr - rd_ptr;
  assign empty              = (count == '0);
  assign full               = (count == (AW+1)'(EVT_FIFO_DEPTH));
  assign event_fifo_fulln_o = !full;
  assign push               = event_fifo_valid_i && !full;
  assign pop                = rd_acc && (reg_addr_i == 3'd4) && !empty;

  // FIFO pointer update; a pop on an empty FIFO is suppressed so a same-cycle push is kept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage has no reset; entries are only read once written.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= event_fifo_data_i;
  end

  // Visible pending vector: stored bits plus the FIFO non-empty flag on the event line.
  assign pend_eff = ((pend_q & PEND_WMASK) | (32'(!empty) << EVT_IRQ_LINE)) & LINE_MASK;
  assign cand     = pend_eff & mask_q;
  assign ack_hit  = (state_q == REQ) && core_irq_ack_i && (core_irq_ack_id_i == id_q);

  // Pending set/clear terms; set is applied after clear so a same-cycle set wins.
  always_comb begin
    set_vec = (mode_q & lines & ~prev_q) | (~mode_q & lines);
    clr_vec = '0;
    if (wr_acc && reg_addr_i == 3'd3) set_vec = set_vec | reg_wdata_i;
    if (wr_acc && reg_addr_i == 3'd1) clr_vec = reg_wdata_i;
    if (ack_hit && mode_q[id_q])      clr_vec[id_q] = 1'b1;
    pend_d = ((pend_q & ~clr_vec) | set_vec) & PEND_WMASK;
  end

  // Configuration and pending registers plus the edge-detect history.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q <= '0;
      mode_q <= '0;
      pend_q <= '0;
      prev_q <= '0;
    end else begin
      prev_q <= lines;
      pend_q <= pend_d;
      if (wr_acc && reg_addr_i == 3'd0) mask_q <= reg_wdata_i & LINE_MASK;
      if (wr_acc && reg_addr_i == 3'd2) mode_q <= reg_wdata_i & LINE_MASK;
    end
  end

  // Read mux; only a read strobe produces data, everything else returns 0.
  always_comb begin
    rdata_d = '0;
    if (rd_acc) begin
      case (reg_addr_i)
        3'd0:    rdata_d = mask_q;
        3'd1:    rdata_d = pend_eff;
        3'd2:    rdata_d = mode_q;
        3'd4:    rdata_d = empty ? 32'd0 : 32'(mem[rd_ptr[AW-1:0]]);
        3'd5:    rdata_d = {16'(count), 14'b0, full, empty};
        default: rdata_d = '0;
      endcase
    end
  end

  // Register the read response one cycle after the strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_rdata_o  <= '0;
      reg_rvalid_o <= 1'b0;
    end else begin
      reg_rdata_o  <= rdata_d;
      reg_rvalid_o <= reg_req_i;
    end
  end

  // Highest-index candidate wins.
  always_comb begin
    sel_id = '0;
    for (int i = 0; i < NB_IRQ; i++) begin
      if (cand[i]) sel_id = ID_WIDTH'(i);
    end
    has_cand = |cand;
  end

  // FSM state and latched id.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
    end
  end

  // Next state: ack beats withdrawal, and a new higher-priority line never preempts REQ.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (has_cand) begin
          state_d = REQ;
          id_d    = sel_id;
        end
      end
      REQ: begin
        if (ack_hit)            state_d = GAP;
        else if (!cand[id_q])   state_d = IDLE;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only, so reset clears them asynchronously.
  always_comb begin
    core_irq_req_o = (state_q == REQ);
    core_irq_id_o  = id_q;
`ifdef FC_IRQ_ONEHOT_EN
    core_irq_onehot_o = core_irq_req_o ? (NB_IRQ'(1) << id_q) : '0;
`else
    core_irq_onehot_o = '0;
`endif
  end

endmodule

// File: tb/tb_fc_irq_ctrl_gen.sv
// Directed bench for fc_irq_ctrl_gen with default parameters and hand-computed expectations.
module tb_fc_irq_ctrl_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] irq_lines;
  logic        evt_vld;
  logic        evt_fulln;
  logic [7:0]  evt_dat;
  logic        reg_req, reg_we;
  logic [2:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic        reg_rvalid;
  logic        irq_req;
  logic [4:0]  irq_id;
  logic [31:0] irq_onehot;
  logic        irq_ack;
  logic [4:0]  irq_ack_id;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  fc_irq_ctrl_gen dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .irq_lines_i        (irq_lines),
    .event_fifo_valid_i (evt_vld),
    .event_fifo_fulln_o (evt_fulln),
    .event_fifo_data_i  (evt_dat),
    .reg_req_i          (reg_req),
    .reg_we_i           (reg_we),
    .reg_addr_i         (reg_addr),
    .reg_wdata_i        (reg_wdata),
    .reg_rdata_o        (reg_rdata),
    .reg_rvalid_o       (reg_rvalid),
    .core_irq_req_o     (irq_req),
    .core_irq_id_o      (irq_id),
    .core_irq_onehot_o  (irq_onehot),
    .core_irq_ack_i     (irq_ack),
    .core_irq_ack_id_i  (irq_ack_id)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
    reg_req = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_req = 1'b0; reg_we = 1'b0; reg_wdata = '0;
  endtask

  task automatic reg_rd(input logic [2:0] a, output logic [31:0] d);
    reg_req = 1'b1; reg_we = 1'b0; reg_addr = a;
    tick();
    reg_req = 1'b0;
    check("rvalid", {31'b0, reg_rvalid}, 32'd1);
    d = reg_rdata;
  endtask

  task automatic ack(input logic [4:0] id);
    irq_ack = 1'b1; irq_ack_id = id;
    tick();
    irq_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; irq_lines = '0; evt_vld = 1'b0; evt_dat = '0;
    reg_req = 1'b0; reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
    irq_ack = 1'b0; irq_ack_id = '0;

    // Reset values
    #3;
    check("rst_req", {31'b0, irq_req}, 32'd0);
    check("rst_id", {27'b0, irq_id}, 32'd0);
    check("rst_onehot", irq_onehot, 32'd0);
    check("rst_fulln", {31'b0, evt_fulln}, 32'd1);
    check("rst_rvalid", {31'b0, reg_rvalid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Edge line 0 pulse, request, ack, gap
    reg_wr(3'd2, 32'h1);
    reg_wr(3'd0, 32'h1);
    irq_lines = 32'h1;
    tick();
    irq_lines = '0;
    check("t1_req_latency", {31'b0, irq_req}, 32'd0);
    tick();
    check("t1_req", {31'b0, irq_req}, 32'd1);
    check("t1_id", {27'b0, irq_id}, 32'd0);
    ack(5'd0);
    check("t1_gap", {31'b0, irq_req}, 32'd0);
    tick();
    check("t1_idle", {31'b0, irq_req}, 32'd0);
    reg_rd(3'd1, rd);
    check("t1_pending", rd, 32'd0);
    check("t1_stays_low", {31'b0, irq_req}, 32'd0);

    // Priority: lines 3 and 17 together, edge mode
    reg_wr(3'd0, 32'hFFFF_FFFF);
    reg_wr(3'd2, 32'h0002_0009);
    irq_lines = 32'h0002_0008;
    tick();
    irq_lines = '0;
    tick();
    check("t2_req", {31'b0, irq_req}, 32'd1);
    check("t2_id17", {27'b0, irq_id}, 32'd17);
    ack(5'd3);
    check("t2_badack_req", {31'b0, irq_req}, 32'd1);
    check("t2_badack_id", {27'b0, irq_id}, 32'd17);
    ack(5'd17);
    check("t2_gap", {31'b0, irq_req}, 32'd0);
    tick();
    check("t2_idle", {31'b0, irq_req}, 32'd0);
    tick();
    check("t2_req3", {31'b0, irq_req}, 32'd1);
    check("t2_id3", {27'b0, irq_id}, 32'd3);
    ack(5'd3);
    tick();
    reg_rd(3'd1, rd);
    check("t2_pending", rd, 32'd0);

    // Withdrawal when masked off in REQ
    reg_wr(3'd3, 32'h20);
    tick();
    check("t3_req", {31'b0, irq_req}, 32'd1);
    check("t3_id5", {27'b0, irq_id}, 32'd5);
    reg_wr(3'd0, 32'h0);
    tick();
    check("t3_withdrawn", {31'b0, irq_req}, 32'd0);
    reg_rd(3'd1, rd);
    check("t3_pending5", rd, 32'h20);
    reg_rd(3'd3, rd);
    check("t3_set_reads0", rd, 32'd0);
    reg_wr(3'd1, 32'h20);
    reg_rd(3'd1, rd);
    check("t3_w1c", rd, 32'd0);

    // Event FIFO fill, overflow drop, drain
    for (int i = 0; i < 8; i++) begin
      evt_vld = 1'b1; evt_dat = 8'h10 + 8'(i);
      tick();
    end
    evt_vld = 1'b0;
    check("t4_fulln0", {31'b0, evt_fulln}, 32'd0);
    reg_rd(3'd5, rd);
    check("t4_status_full", rd, 32'h0008_0002);
    reg_rd(3'd1, rd);
    check("t4_pend26", rd, 32'h0400_0000);
    evt_vld = 1'b1; evt_dat = 8'h99;
    tick();
    evt_vld = 1'b0;
    reg_rd(3'd5, rd);
    check("t4_status_drop", rd, 32'h0008_0002);
    for (int i = 0; i < 8; i++) begin
      reg_rd(3'd4, rd);
      check("t4_pop", rd, 32'h10 + 32'(i));
    end
    check("t4_fulln1", {31'b0, evt_fulln}, 32'd1);
    reg_rd(3'd1, rd);
    check("t4_pend26_clr", rd, 32'd0);
    reg_rd(3'd5, rd);
    check("t4_status_empty", rd, 32'h0000_0001);
    // Push and pop in the same cycle on an empty FIFO
    evt_vld = 1'b1; evt_dat = 8'h55;
    reg_rd(3'd4, rd);
    evt_vld = 1'b0;
    check("t4_pop_empty", rd, 32'd0);
    reg_rd(3'd4, rd);
    check("t4_pop_pushed", rd, 32'h55);

    // Level line 2 held high
    reg_wr(3'd2, 32'h0);
    reg_wr(3'd0, 32'h4);
    irq_lines = 32'h4;
    tick();
    tick();
    check("t5_req", {31'b0, irq_req}, 32'd1);
    check("t5_id2", {27'b0, irq_id}, 32'd2);
    ack(5'd2);
    check("t5_gap", {31'b0, irq_req}, 32'd0);
    reg_rd(3'd1, rd);
    check("t5_reset_pend", rd, 32'h4);
    tick();
    check("t5_rereq", {31'b0, irq_req}, 32'd1);
    check("t5_reid", {27'b0, irq_id}, 32'd2);
    irq_lines = '0;
    reg_wr(3'd1, 32'h4);
    tick();
    check("t5_done", {31'b0, irq_req}, 32'd0);

    // Reset in the middle of a request with a full FIFO
    for (int i = 0; i < 8; i++) begin
      evt_vld = 1'b1; evt_dat = 8'(i);
      tick();
    end
    evt_vld = 1'b0;
    reg_wr(3'd3, 32'h4);
    tick();
    check("t6_req", {31'b0, irq_req}, 32'd1);
    check("t6_fulln0", {31'b0, evt_fulln}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_req", {31'b0, irq_req}, 32'd0);
    check("t6_rst_id", {27'b0, irq_id}, 32'd0);
    check("t6_rst_onehot", irq_onehot, 32'd0);
    check("t6_rst_fulln", {31'b0, evt_fulln}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    reg_rd(3'd0, rd);
    check("t6_mask0", rd, 32'd0);
    reg_rd(3'd5, rd);
    check("t6_status", rd, 32'h0000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fc_irq_ctrl_gen.md
Name: fc_irq_ctrl_gen

Overview:
Parametrised fabric-controller interrupt controller. It is the next generation of the FC event unit.
- Generalises line count, event-FIFO depth and priority selection.
- Adds per-line edge/level mode and request withdrawal.
- Adds an optional one-hot output for cores that read IRQ lines directly.
- Sits between SoC event sources and the FC core's irq/ack interface; configured through a simple register port.

Parameters:
NB_IRQ, 32, number of interrupt lines (2..32)
EVT_ID_WIDTH, 8, event FIFO data width (<=32)
EVT_FIFO_DEPTH, 8, event FIFO entries (power of two, >=2)
EVT_IRQ_LINE, 26, line index asserted while event FIFO is non-empty
ID_WIDTH, $clog2(NB_IRQ), IRQ id width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
irq_lines_i  in  NB_IRQ  raw interrupt lines (synchronous to clk_i)
event_fifo_valid_i  in  1  event push request
event_fifo_fulln_o  out  1  high when FIFO can accept
event_fifo_data_i  in  EVT_ID_WIDTH  event id
reg_req_i  in  1  register access strobe
reg_we_i  in  1  1=write
reg_addr_i  in  3  word index
reg_wdata_i  in  32  write data
reg_rdata_o  out  32  read data
reg_rvalid_o  out  1  response valid
core_irq_req_o  out  1  interrupt request to core
core_irq_id_o  out  ID_WIDTH  requested id
core_irq_onehot_o  out  NB_IRQ  one-hot request (see optional feature)
core_irq_ack_i  in  1  core acknowledge pulse
core_irq_ack_id_i  in  ID_WIDTH  acknowledged id

Behaviour:
Reset values:
- All outputs 0, except event_fifo_fulln_o=1.
- MASK=0, PENDING=0, MODE=0, FIFO empty, FSM=IDLE.

Register port:
- reg_rvalid_o is asserted exactly one cycle after reg_req_i. Reads return registered data.
- Index 0 MASK: RW.
- Index 1 PENDING: read; write-1-to-clear.
- Index 2 MODE: RW; 1=edge, 0=level.
- Index 3 SET: write-1-to-set PENDING; reads 0.
- Index 4 FIFO: read pops head; {zero-extend, data}. Read when empty returns 0 with no pop.
- Index 5 STATUS: {count[15:0], 14'b0, full, empty}.
- Other indices read 0; writes to them are ignored.
- Bits >= NB_IRQ read 0.

Pending logic, per cycle:
- Edge line: set on 0->1 of irq_lines_i (previous value registered).
- Level line: set while irq_lines_i is high.
- PENDING[EVT_IRQ_LINE] is forced to !empty. It is not writable.
- Same-cycle set and clear (W1C or ack): set wins.

Event FIFO:
- Push when valid_i && fulln_o.
- fulln_o = !full, registered from current state.
- Push while full: the event is dropped; no state change.
- Simultaneous push and pop when empty: the pop returns 0 and the push is stored.
- Count wraps are handled by pointers with an extra bit.

Selection:
- Candidate = PENDING & MASK. The highest index wins.

FSM:
- IDLE: if candidate != 0, latch id and go to REQ. core_irq_req_o rises the cycle after the candidate appears (1-cycle latency).
- REQ: req_o=1 and id is held stable.
  - On ack_i with ack_id == latched id: clear PENDING[id] if edge mode, go to GAP.
  - If the latched line is no longer in the candidate set (masked or cleared) and no ack arrives: withdraw, drop req_o next cycle, go to IDLE.
  - A higher-priority arrival does not preempt REQ.
  - An ack with a mismatched id is ignored.
- GAP: one cycle with req_o=0, then IDLE. This lets level sources deassert.
- Reset mid-REQ: immediate return to IDLE; req_o=0 asynchronously.

Optional Feature:
FC_IRQ_ONEHOT_EN
- Defined: core_irq_onehot_o = req_o ? (1 << id) : 0, from the same registers (same timing as req_o).
- Undefined: core_irq_onehot_o is tied to 0 and no decode logic is built.

Test Plan:
- MODE=1, MASK=0x1, pulse irq_lines_i[0] one cycle -> req_o=1, id=0 one cycle later. Ack id 0 -> PENDING=0, req_o low for the GAP cycle and stays low.
- MASK=0xFFFFFFFF, raise lines 3 and 17 together -> id=17. After ack: GAP cycle, then id=3.
- In REQ for id 5, write MASK=0 -> req_o drops next cycle; FSM in IDLE; PENDING[5] is still 1.
- Push 8 events (0x10..0x17), depth 8 -> fulln_o=0 after the 8th; a 9th push is dropped. Eight FIFO reads return 0x10..0x17. PENDING[26] clears after the last pop.
- Level line 2 held high with MASK=0x4 -> req_o=1. After ack: PENDING[2] re-sets. After GAP, id=2 is re-requested until the line falls.
- Assert rst_ni=0 during REQ -> req_o, id and onehot go to 0 immediately; fulln_o=1.
